// File: rtl/mult_seq_core_if.sv
// mult_seq_core_if
//   Bundles the operand/start inputs and the result outputs of the sequential
//   multiplier core so the peripheral and the core share one connection.
//
//   Signals:
//     init  start request level (0->1 edge starts an operation)
//     A     multiplicand, WIDTH bits
//     B     multiplier, WIDTH bits
//     pp    product, 2*WIDTH bits
//     done  result valid, held until the next start or reset
//     busy  operation in progress
//
//   Modports:
//     master  software/peripheral side: drives init, A, B; reads pp, done, busy
//     slave   multiplier core side
interface mult_seq_core_if #(
    parameter int WIDTH = 16
);
    logic                 init;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2*WIDTH-1:0]   pp;
    logic                 done;
    logic                 busy;

    modport master (
        output init, A, B,
        input  pp, done, busy
    );

    modport slave (
        input  init, A, B,
        output pp, done, busy
    );
endinterface

// File: rtl/mult_seq_core.sv
// mult_seq_core
//   Sequential unsigned shift-and-add multiplier. One multiplier bit is
//   retired per clock; the product and done flag are held until the next
//   start edge on init (a 0->1 transition seen while IDLE or DONE).
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-low reset, clears all state
//     bus   mult_seq_core_if.slave: init, A, B in; pp, done, busy out
//
//   Optional feature macro: MULT_EARLY_EXIT_EN
//     When defined, RUN also ends as soon as no set multiplier bits remain,
//     so latency becomes max(1, msb index of B + 1). The product is the same
//     in both builds.
module mult_seq_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    mult_seq_core_if.slave   bus
);

    localparam int               PW       = 2 * WIDTH;
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic                init_q;
    logic [PW-1:0]       a_sh_q;
    logic [WIDTH-1:0]    b_sh_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PW-1:0]       pp_q;
    logic                done_q;
    logic                busy_q;

    logic                start_d;
    logic [PW-1:0]       pp_d;
    logic                last_d;

    always_comb begin
        // A rising init is only honoured outside RUN; init_q keeps tracking
        // during RUN so a level raised mid-run never fires later.
        start_d = bus.init && !init_q && (state_q != RUN);
        // Full-width add: a_sh never exceeds 2*WIDTH bits over WIDTH shifts,
        // and the running sum is bounded by the final product.
        pp_d    = b_sh_q[0] ? (pp_q + a_sh_q) : pp_q;
`ifdef MULT_EARLY_EXIT_EN
        last_d  = (cnt_q == CNT_LAST) || ((b_sh_q >> 1) == '0);
`else
        last_d  = (cnt_q == CNT_LAST);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            pp_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            init_q <= bus.init;
            case (state_q)
                RUN: begin
                    pp_q   <= pp_d;
                    a_sh_q <= a_sh_q << 1;
                    b_sh_q <= b_sh_q >> 1;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_d) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    // IDLE and DONE: results hold until a start edge.
                    if (start_d) begin
                        a_sh_q  <= {{WIDTH{1'b0}}, bus.A};
                        b_sh_q  <= bus.B;
                        pp_q    <= '0;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
            endcase
        end
    end

    assign bus.pp   = pp_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_mult_seq_core.sv
// tb_mult_seq_core
//   Self-checking bench for mult_seq_core: table of operand/product vectors
//   plus hand-written sequences for reset, held init and ignored restarts.
//   Expected products and latencies go into a scoreboard queue at start and
//   are compared when done rises.
module tb_mult_seq_core;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mult_seq_core_if #(.WIDTH(W)) bus ();

    mult_seq_core #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] pp;
    } vec_t;

    typedef struct {
        logic [31:0] pp;
        int          lat;
    } sb_t;

    vec_t vecs[8];
    sb_t  sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic int exp_lat(input logic [15:0] b);
        int l;
        l = 1;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) l = i + 1;
        end
`ifndef MULT_EARLY_EXIT_EN
        l = W;
`endif
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drops init for one edge, then raises it with new operands; the next
    // edge is the start edge E0.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp_pp);
        sb_t e;
        bus.init = 1'b0;
        tick();
        bus.A    = a;
        bus.B    = b;
        bus.init = 1'b1;
        e.pp  = exp_pp;
        e.lat = exp_lat(b);
        sb.push_back(e);
        tick();
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("done_after_start", 32'(bus.done), 32'd0);
    endtask

    // Counts edges after E0 (already = edges consumed by the caller) until
    // done, bounded to 40 edges.
    task automatic wait_done(input int already);
        int  k;
        bit  seen;
        sb_t e;
        k    = already;
        seen = 1'b0;
        while (k < 40 && !seen) begin
            tick();
            k++;
            check("done_busy_excl", 32'(bus.done & bus.busy), 32'd0);
            if (bus.done) seen = 1'b1;
            else          check("busy_during_run", 32'(bus.busy), 32'd1);
        end
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: actual=empty required=entry at %0t", $time);
            return;
        end
        e = sb.pop_front();
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: actual=no done in %0d edges required=done after %0d", k, e.lat);
        end else begin
            check("latency", 32'(k), 32'(e.lat));
            check("product", bus.pp, e.pp);
            check("busy_at_done", 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        sb_t drop;

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[2] = '{16'h1234, 16'h0001, 32'h0000_1234};
        vecs[3] = '{16'h1234, 16'h0000, 32'h0000_0000};
        vecs[4] = '{16'h0002, 16'h8000, 32'h0001_0000};
        vecs[5] = '{16'hABCD, 16'h1234, 32'h0C37_4FA4};
        vecs[6] = '{16'h8000, 16'h8000, 32'h4000_0000};
        vecs[7] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};

        // Reset state, with init already high so the first edge after
        // release is a start.
        rst      = 1'b0;
        bus.init = 1'b1;
        bus.A    = 16'h0003;
        bus.B    = 16'h0005;
        #22;
        check("reset_pp",   bus.pp,            32'd0);
        check("reset_done", 32'(bus.done),     32'd0);
        check("reset_busy", 32'(bus.busy),     32'd0);
        begin
            sb_t e;
            e.pp  = 32'h0000_000F;
            e.lat = exp_lat(16'h0005);
            sb.push_back(e);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("init_at_release_busy", 32'(bus.busy), 32'd1);
        wait_done(0);

        // Table-driven products.
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].pp);
            wait_done(0);
        end

        // Level-held init: no retrigger, operand changes ignored.
        start_op(16'h0003, 16'h0005, 32'h0000_000F);
        wait_done(0);
        bus.A = 16'h0007;
        repeat (4) tick();
        check("held_pp",   bus.pp,        32'h0000_000F);
        check("held_done", 32'(bus.done), 32'd1);
        check("held_busy", 32'(bus.busy), 32'd0);
        start_op(16'h0007, 16'h0005, 32'h0000_0023);
        wait_done(0);

        // Asynchronous reset in the middle of RUN.
        start_op(16'h1234, 16'h8000, 32'h091A_0000);
        repeat (8) tick();
        #2;
        rst = 1'b0;
        #1;
        check("midrst_pp",   bus.pp,        32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        drop = sb.pop_front();
        bus.init = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        check("post_rst_idle_busy", 32'(bus.busy), 32'd0);
        check("post_rst_idle_done", 32'(bus.done), 32'd0);
        start_op(16'h1234, 16'h8000, 32'h091A_0000);
        wait_done(0);

        // Restart pulse during RUN is ignored.
        start_op(16'h00F0, 16'h00FF, 32'h0000_EF10);
        repeat (3) tick();
        bus.init = 1'b0;
        bus.A    = 16'hFFFF;
        bus.B    = 16'hFFFF;
        tick();
        bus.init = 1'b1;
        tick();
        wait_done(5);
        repeat (3) tick();
        check("ignored_hold_pp",   bus.pp,        32'h0000_EF10);
        check("ignored_hold_done", 32'(bus.done), 32'd1);
        check("ignored_hold_busy", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mult_seq_core.md
# mult_seq_core

Sequential unsigned shift-and-add multiplier, the arithmetic core driven by the memory-mapped multiplier peripheral. It consumes the operand registers (A, B) and the init level written by software, and produces the product and a done flag that the peripheral returns on reads. The block retires one multiplier bit per clock and holds its result until the next start.

## Interface
- WIDTH, 16, operand width in bits; the product is 2*WIDTH bits.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset. Assertion clears all state immediately, independent of clk.
- init  in  1  start request. This is a level that software sets and clears. A start occurs only on a 0→1 transition.
- A  in  WIDTH  multiplicand; sampled only at the start edge.
- B  in  WIDTH  multiplier; sampled only at the start edge.
- pp  out  2*WIDTH  product accumulator; holds the final product while done=1.
- done  out  1  result valid; held high until the next start or reset.
- busy  out  1  high while an operation is in progress (RUN state).

## Operation
- Internal registers:
  - init_q: init delayed by one clock, used for edge detection.
  - a_sh: 2*WIDTH bits, shifted left.
  - b_sh: WIDTH bits, shifted right.
  - cnt: log2(WIDTH) bits.
  - state.
- States: IDLE, RUN, DONE. The reset state is IDLE.
- Start condition: init=1 and init_q=0, sampled while state is IDLE or DONE.
- On a start edge:
  - a_sh ← zero-extended A; b_sh ← B; pp ← 0; cnt ← 0.
  - done ← 0; state ← RUN.
- In RUN, each edge:
  - If b_sh[0]=1, then pp ← pp + a_sh, a full 2*WIDTH-bit add. No overflow is possible.
  - a_sh ← a_sh<<1; b_sh ← b_sh>>1; cnt ← cnt+1.
  - When cnt = WIDTH-1, state ← DONE and done ← 1.
- In DONE: pp and done hold. A new start edge restarts the operation from DONE.
- A start edge during RUN is ignored. init_q still tracks init, so a rise-and-hold of init during RUN does not start a new operation afterward.
- Holding init high does not retrigger. Software must write init=0 and then init=1 to start again.
- Arithmetic is unsigned only.

## Timing
- Reset values:
  - pp=0, done=0, busy=0.
  - state=IDLE; init_q=0; a_sh, b_sh and cnt all 0.
- If init is already 1 when rst deasserts, a start occurs on the first clock edge (because init_q resets to 0).
- Latency with the configured feature off:
  - Start sampled at edge E0.
  - busy=1 from after E0 through E16.
  - done=1 and busy=0 after edge E16, which is WIDTH edges after the start.
- Reset during RUN: outputs clear immediately, the operation is lost, and no done pulse is produced.
- Operands changing after E0 have no effect on the operation in progress.
- done=1 and busy=1 are never true at the same time.

## Configuration
- MULT_EARLY_EXIT_EN defined:
  - RUN also ends on any edge where (b_sh>>1)=0, i.e. no multiplier bits remain.
  - Latency becomes max(1, index of the most significant set bit of B + 1) edges.
  - B=0 gives done after E1 with pp=0.
- MULT_EARLY_EXIT_EN undefined: latency is always WIDTH edges, independent of the operands.
- In both configurations the product value is identical.

## Test plan
- Basic product, early exit off:
  - A=16'h0003, B=16'h0005, rise init.
  - Expect pp=32'h0000000F and done=1 exactly 16 edges after the start edge; busy high for 16 cycles.
- Maximum operands:
  - A=B=16'hFFFF.
  - Expect pp=32'hFFFE0001, done=1.
- Early exit on:
  - A=16'h1234, B=16'h0001: expect pp=32'h00001234 with done after 1 edge.
  - A=16'h1234, B=16'h0000: expect pp=0 with done after 1 edge.
  - A=16'h0002, B=16'h8000: expect pp=32'h00010000 with done after 16 edges.
- Level-held init:
  - Hold init=1 after done, change A to 16'h0007.
  - Expect pp unchanged and no restart.
  - Drop and re-raise init: expect a new operation with the new operands.
- Reset mid-operation:
  - Assert rst low asynchronously (between clock edges) at cycle 8 of RUN.
  - Expect pp=0, done=0, busy=0 immediately.
  - After release with init=0 and re-raising init, expect a correct product.
- Ignored restart:
  - Re-pulse init during RUN with new A and B.
  - Expect the original product at the original latency, then state DONE.
